dual_port_ram: RTL and testbench

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

---
 rtl/ram_pkg.sv | 8 +
 rtl/dual_port_ram.sv | 74 +++++++
 tb/tb_dual_port_ram.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared defaults for the dual-port RAM and everything that talks to it.
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 4;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

endpackage : ram_pkg

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, shared clock.
// Storage is a flop array so the whole contents can be cleared asynchronously.
// A read and write to the same location at one edge returns the new data.
// Locations at or above DEPTH do not exist: writes there are dropped and
// reads there return zero.
module dual_port_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      wr_sel_d;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // One-hot write strobe per location; out-of-range addresses select nothing.
    always_comb begin
        wr_sel_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_enb && (wr_addr == ADDR_WIDTH'(i))) begin
                wr_sel_d[i] = 1'b1;
            end
        end
    end

    // Storage array: cleared asynchronously, written on the selected location.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel_d[i]) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    // Read mux with write-first bypass; unmatched (out-of-range) address reads zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_data_d = wr_sel_d[i] ? wr_data : mem_q[i];
            end
        end
    end

    // Read result register: loads on rd_enb, holds otherwise, zeroed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_enb) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed scenarios plus a randomized run, checked
// against an array model. A second instance with DEPTH=12 covers the
// nonexistent-address behaviour.
module tb_dual_port_ram;
    import ram_pkg::*;

    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;
    localparam int D  = RAM_DEPTH;
    localparam int DS = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_enb = 1'b0;
    logic          rd_enb = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] rd_data_s;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m_full  [D];
    logic [DW-1:0] m_small [D];
    logic [DW-1:0] e_full  = '0;
    logic [DW-1:0] e_small = '0;

    dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    dual_port_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DS)) dut_s (
        .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_full[i]  = '0;
            m_small[i] = '0;
        end
        e_full  = '0;
        e_small = '0;
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, check both outputs.
    task automatic cyc(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic re, input int ra, input string tag);
        wr_enb  = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        rd_enb  = re;
        rd_addr = AW'(ra);
        @(posedge clk);
        if (!rst) begin
            if (re) begin
                e_full  = (we && wa == ra) ? wd : m_full[ra];
                e_small = (ra >= DS) ? '0 : ((we && wa == ra) ? wd : m_small[ra]);
            end
            if (we) begin
                m_full[wa] = wd;
                if (wa < DS) m_small[wa] = wd;
            end
        end
        #1;
        chk(tag, rd_data, e_full);
        chk({tag, "_d12"}, rd_data_s, e_small);
        wr_enb = 1'b0;
        rd_enb = 1'b0;
    endtask

    initial begin
        int wa, ra;
        logic we, re;
        logic [DW-1:0] wd;
        model_reset();

        // Reset state
        #3;
        chk("reset_rd", rd_data, '0);
        chk("reset_rd_d12", rd_data_s, '0);
        @(negedge clk);
        rst = 1'b0;

        // Write then read
        cyc(1, 3, 8'hA5, 0, 0, "wr3");
        cyc(0, 0, 8'h00, 1, 3, "rd3_A5");
        chk("rd3_A5_const", rd_data, 8'hA5);

        // Same-address collision, write-first
        cyc(1, 7, 8'h11, 0, 0, "wr7_11");
        cyc(1, 7, 8'h3C, 1, 7, "coll7");
        chk("coll7_const", rd_data, 8'h3C);
        cyc(0, 0, 8'h00, 1, 7, "rd7_after");
        chk("rd7_after_const", rd_data, 8'h3C);

        // Different-address concurrency
        cyc(1, 9, 8'h9E, 0, 0, "wr9");
        cyc(1, 2, 8'h55, 1, 9, "conc_rd9");
        chk("conc_rd9_const", rd_data, 8'h9E);
        cyc(0, 0, 8'h00, 1, 2, "rd2");
        chk("rd2_const", rd_data, 8'h55);

        // Hold with rd_enb low while the location changes
        cyc(0, 0, 8'h00, 1, 3, "hold_rd3");
        for (int i = 0; i < 5; i++) begin
            cyc(1, 3, 8'hFF, 0, 0, "hold");
            chk("hold_const", rd_data, 8'hA5);
        end

        // Out-of-range behaviour on the 12-deep instance
        cyc(1, 13, 8'h77, 0, 0, "wr13");
        cyc(0, 0, 8'h00, 1, 13, "rd13");
        chk("rd13_d12_zero", rd_data_s, '0);

        // Async reset mid-stream
        for (int a = 0; a < 16; a++) cyc(1, a, DW'(16 + a), 0, 0, "fill");
        cyc(0, 0, 8'h00, 1, 5, "pre_rst_rd5");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_rd", rd_data, '0);
        chk("async_rst_rd_d12", rd_data_s, '0);
        cyc(1, 4, 8'hEE, 1, 4, "in_rst_ops");
        #3;
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            cyc(0, 0, 8'h00, 1, a, "post_rst_rd");
            chk("post_rst_zero", rd_data, '0);
        end

        // Streaming writes then reads
        for (int a = 0; a < 16; a++) cyc(1, a, DW'(a), 0, 0, "stream_wr");
        for (int a = 0; a < 16; a++) begin
            cyc(0, 0, 8'h00, 1, a, "stream_rd");
            chk("stream_seq", rd_data, DW'(a));
        end

        // Randomized traffic with biased collisions
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = $urandom_range(0, D - 1);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, D - 1);
            wd = DW'($urandom);
            cyc(we, wa, wd, re, ra, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dual_port_ram
